// File: rtl/hazard_scoreboard_pkg.sv
// Shared defaults and helpers for the hazard scoreboard.
package hazard_scoreboard_pkg;

  localparam int unsigned NumRegsDefault     = 32;
  localparam int unsigned RegWDefault        = 5;
  localparam int unsigned LatWDefault        = 4;
  localparam int unsigned FlushCyclesDefault = 2;

  // Bits needed to hold 0..max_val; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard_entry.sv
// One scoreboard entry: busy flag plus latency countdown. A count of all-ones
// marks a sticky entry that only a matching writeback can release.
module hazard_scoreboard_entry
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned LAT_W = LatWDefault
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic [LAT_W-1:0] alloc_lat,
  input  logic             wb_hit,
  output logic             busy,
  output logic             sticky
);

  localparam logic [LAT_W-1:0] LatWait = '1;

  logic             busy_q, busy_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;

  assign busy   = busy_q;
  assign sticky = busy_q & (cnt_q == LatWait);

  // Next state: allocation beats a same-cycle expiry or writeback.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (alloc) begin
      busy_d = 1'b1;
      cnt_d  = alloc_lat;
    end else if (busy_q) begin
      if (sticky) begin
        if (wb_hit) begin
          busy_d = 1'b0;
          cnt_d  = '0;
        end
      end else if (cnt_q == LAT_W'(1)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q - LAT_W'(1);
      end
    end
  end

  // Entry state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard with RAW/WAW stall and multi-cycle
// mispredict flush for the pipelined core.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS     = NumRegsDefault,
  parameter int unsigned REG_W        = RegWDefault,
  parameter int unsigned LAT_W        = LatWDefault,
  parameter int unsigned FLUSH_CYCLES = FlushCyclesDefault
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs1,
  input  logic [REG_W-1:0]    id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic [REG_W-1:0]    id_rd,
  input  logic                id_writes_rd,
  input  logic [LAT_W-1:0]    id_lat,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  input  logic                ex_mispredict,
  output logic                stall,
  output logic                flush,
  output logic                issue,
  output logic [NUM_REGS-1:0] pending_mask
);

  localparam int unsigned FlW = cnt_width(FLUSH_CYCLES);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] sticky;
  logic                alloc_ok;
  logic                raw;
  logic                waw;
  logic [FlW-1:0]      flush_cnt_q, flush_cnt_d;

  // x0 is never tracked.
  assign busy[0]      = 1'b0;
  assign sticky[0]    = 1'b0;
  assign pending_mask = busy;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_scoreboard_entry #(
      .LAT_W(LAT_W)
    ) u_entry (
      .clk      (clk),
      .reset    (reset),
      .alloc    (alloc_ok & (id_rd == REG_W'(r))),
      .alloc_lat(id_lat),
      .wb_hit   (wb_valid & (wb_rd == REG_W'(r))),
      .busy     (busy[r]),
      .sticky   (sticky[r])
    );
  end

  // Hazard detection and issue; all combinational from state and ID inputs.
  always_comb begin
    raw   = 1'b0;
    waw   = 1'b0;
    stall = 1'b0;
    issue = 1'b0;
    flush = ex_mispredict | (flush_cnt_q != '0);
    raw   = id_valid & ((id_use_rs1 & (id_rs1 != '0) & busy[id_rs1]) |
                        (id_use_rs2 & (id_rs2 != '0) & busy[id_rs2]));
    // A second write behind an unknown-latency one would reorder writeback.
    waw   = id_valid & id_writes_rd & (id_rd != '0) & sticky[id_rd];
    stall = (raw | waw) & ~flush;
    issue = id_valid & ~stall & ~flush;
  end

  // Latency 0 is fully bypassed and needs no entry.
  assign alloc_ok = issue & id_writes_rd & (id_rd != '0) & (id_lat != '0);

  // Flush countdown; a new mispredict reloads it.
  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (ex_mispredict) begin
      flush_cnt_d = FlW'(FLUSH_CYCLES);
    end else if (flush_cnt_q != '0) begin
      flush_cnt_d = flush_cnt_q - FlW'(1);
    end
  end

  // Flush counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      flush_cnt_q <= '0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed vector table, reset sequence, then
// random stimulus against an integer-level reference model.
module tb_hazard_scoreboard;

  localparam int NR = 32;
  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, id_writes_rd;
  logic [3:0]  id_lat;
  logic        wb_valid, ex_mispredict;
  logic        stall, flush, issue;
  logic [31:0] pending_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(
    .NUM_REGS(NR), .REG_W(5), .LAT_W(4), .FLUSH_CYCLES(FC)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_writes_rd(id_writes_rd), .id_lat(id_lat), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .ex_mispredict(ex_mispredict), .stall(stall), .flush(flush), .issue(issue),
    .pending_mask(pending_mask)
  );

  typedef struct {
    logic rst; logic vld; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2;
    logic [4:0] rd; logic wr; logic [3:0] lat; logic wbv; logic [4:0] wbrd; logic mis;
    logic e_stall; logic e_flush; logic e_issue; logic [31:0] e_pend;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] bit_of(input int r);
    return 32'd1 << r;
  endfunction

  function automatic vec_t mk(input int rst, vld, rs1, rs2, u1, u2, rd, wr, lat, wbv, wbrd,
                              mis, es, ef, ei, input logic [31:0] ep);
    vec_t v;
    v.rst = 1'(rst); v.vld = 1'(vld); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.u1 = 1'(u1); v.u2 = 1'(u2); v.rd = 5'(rd); v.wr = 1'(wr); v.lat = 4'(lat);
    v.wbv = 1'(wbv); v.wbrd = 5'(wbrd); v.mis = 1'(mis);
    v.e_stall = 1'(es); v.e_flush = 1'(ef); v.e_issue = 1'(ei); v.e_pend = ep;
    return v;
  endfunction

  function automatic vec_t idle(input logic [31:0] ep);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ep);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2;
    id_use_rs1 = v.u1; id_use_rs2 = v.u2; id_rd = v.rd; id_writes_rd = v.wr;
    id_lat = v.lat; wb_valid = v.wbv; wb_rd = v.wbrd; ex_mispredict = v.mis;
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    drive(v);
    @(negedge clk);
    chk({tag, " stall"}, 32'(stall), 32'(v.e_stall));
    chk({tag, " flush"}, 32'(flush), 32'(v.e_flush));
    chk({tag, " issue"}, 32'(issue), 32'(v.e_issue));
    chk({tag, " pending"}, pending_mask, v.e_pend);
    @(posedge clk);
    #1;
  endtask

  // Reference model: cycles left per timed register, sticky flags, flush cycles left.
  int m_rem[NR];
  bit m_stk[NR];
  int m_fl;

  function automatic bit m_busy(input int r);
    return (r != 0) && (m_stk[r] || m_rem[r] > 0);
  endfunction

  task automatic model_eval(output bit es, output bit ef, output bit ei,
                            output logic [31:0] ep);
    bit raw, waw;
    ef  = ex_mispredict || (m_fl > 0);
    raw = id_valid && ((id_use_rs1 && m_busy(int'(id_rs1))) ||
                       (id_use_rs2 && m_busy(int'(id_rs2))));
    waw = id_valid && id_writes_rd && id_rd != 0 && m_stk[id_rd];
    es  = (raw || waw) && !ef;
    ei  = id_valid && !es && !ef;
    ep  = '0;
    for (int r = 0; r < NR; r++) if (m_busy(r)) ep[r] = 1'b1;
  endtask

  task automatic model_step();
    bit es, ef, ei;
    logic [31:0] ep;
    model_eval(es, ef, ei, ep);
    if (reset) begin
      for (int r = 0; r < NR; r++) begin m_rem[r] = 0; m_stk[r] = 0; end
      m_fl = 0;
    end else begin
      for (int r = 1; r < NR; r++) begin
        if (m_stk[r] && wb_valid && int'(wb_rd) == r) m_stk[r] = 0;
        if (m_rem[r] > 0) m_rem[r]--;
      end
      if (ei && id_writes_rd && id_rd != 0 && id_lat != 0) begin
        if (id_lat == 4'd15) begin
          m_stk[id_rd] = 1; m_rem[id_rd] = 0;
        end else begin
          m_stk[id_rd] = 0; m_rem[id_rd] = int'(id_lat);
        end
      end
      m_fl = ex_mispredict ? FC : ((m_fl > 0) ? m_fl - 1 : 0);
    end
  endtask

  initial begin
    // Reset state with a would-be RAW instruction in ID.
    drive(mk(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset flush", 32'(flush), 32'd0);
    chk("reset pending", pending_mask, 32'd0);
    @(posedge clk);
    #1;

    // Load-use.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 1, 0, 0, bit_of(5)));
    tbl.push_back(mk(0, 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    // Multi-cycle, dependent on rs2.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 3, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 1, 0, 7, 1, 1, 8, 1, 0, 0, 0, 0, 1, 0, 0, bit_of(7)));
    tbl.push_back(mk(0, 1, 0, 7, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    // x0 source and use_rs2=0 never stall.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 3, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 7, 1, 0, 8, 1, 0, 0, 0, 0, 0, 0, 1, bit_of(7)));
    tbl.push_back(idle(bit_of(7)));
    tbl.push_back(idle(bit_of(7)));
    tbl.push_back(idle(0));
    // Sticky load; wb to x8 ignored, wb to x9 releases next cycle.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 15, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(0, 1, 9, 0, 1, 0, 10, 1, 0, (i == 2 || i == 5) ? 1 : 0,
                       (i == 2) ? 8 : 9, 0, 1, 0, 0, bit_of(9)));
    tbl.push_back(mk(0, 1, 9, 0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 1, 0));
    // WAW behind sticky x9.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 15, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 1, 0, 0, bit_of(9)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 1, 9, 0, 1, 0, 0, bit_of(9)));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(idle(bit_of(9)));
    tbl.push_back(idle(0));
    // Allocate wins over same-cycle expiry and wb on x9.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 2, 1, 9, 0, 0, 0, 1, bit_of(9)));
    tbl.push_back(idle(bit_of(9)));
    tbl.push_back(idle(bit_of(9)));
    tbl.push_back(idle(0));
    // Mispredict pulse: flush for pulse + FC cycles.
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0, 0, 1, 0));
    // RAW on busy x3 masked by flush; second pulse extends flush.
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, bit_of(3)));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    for (int i = 0; i < tbl.size(); i++) apply_vec($sformatf("vec%0d", i), tbl[i]);

    // Mid-operation reset with sticky x5 and flush active.
    apply_vec("rst_a", mk(0, 1, 0, 0, 0, 0, 5, 1, 15, 0, 0, 0, 0, 0, 1, 0));
    apply_vec("rst_b", mk(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, bit_of(5)));
    apply_vec("rst_c", mk(1, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, bit_of(5)));
    apply_vec("rst_d", mk(0, 1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    // Random phase against the reference model.
    for (int r = 0; r < NR; r++) begin m_rem[r] = 0; m_stk[r] = 0; end
    m_fl = 0;
    for (int c = 0; c < 3000; c++) begin
      bit es, ef, ei;
      logic [31:0] ep;
      reset         = (c == 0) || ($urandom_range(0, 199) == 0);
      id_valid      = ($urandom_range(0, 3) != 0);
      id_rs1        = 5'($urandom_range(0, 7));
      id_rs2        = 5'($urandom_range(0, 7));
      id_use_rs1    = 1'($urandom_range(0, 1));
      id_use_rs2    = 1'($urandom_range(0, 1));
      id_rd         = 5'($urandom_range(0, 7));
      id_writes_rd  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0: id_lat = 4'd0;
        1: id_lat = 4'd1;
        2: id_lat = 4'd2;
        3: id_lat = 4'd3;
        4: id_lat = 4'd15;
        default: id_lat = 4'($urandom_range(0, 15));
      endcase
      wb_valid      = ($urandom_range(0, 3) == 0);
      wb_rd         = 5'($urandom_range(0, 7));
      ex_mispredict = ($urandom_range(0, 15) == 0);
      model_eval(es, ef, ei, ep);
      @(negedge clk);
      chk($sformatf("rand%0d stall", c), 32'(stall), 32'(es));
      chk($sformatf("rand%0d flush", c), 32'(flush), 32'(ef));
      chk($sformatf("rand%0d issue", c), 32'(issue), 32'(ei));
      chk($sformatf("rand%0d pending", c), pending_mask, ep);
      @(posedge clk);
      model_step();
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
